hook_ctrl: RTL and testbench
============================

# hook_ctrl

Sequential controller for the fishing hook and line drawn by the colour/pixel stage. Produces the hook position (1/10-pixel units), the cut flag and the cut-line endpoint. Updates once per video frame, driven by debounced one-pulse user buttons and game events. Sits between the input/collision logic and the combinational pixel-colour block.

## Interface
- H_HOME, 2790: fixed hook x, 1/10 px (line column 279)
- V_HOME, 620: rest/top hook y, 1/10 px (line origin row 62)
- V_MAX, 4700: deepest hook y, 1/10 px
- SINK_STEP, 15: y increment per frame while sinking or falling after cut
- REEL_STEP, 30: y decrement per frame, empty reel
- HOOKED_STEP, 10: y decrement per frame, fish on hook
- CUT_STEP, 2: cut_v decrement per frame, whole pixels
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame (vertical blank)
- btn_cast  in  1  one-cycle pulse, start cast
- btn_reel  in  1  one-cycle pulse, start reel
- fish_hit  in  1  one-cycle pulse, fish collided with hook
- cut_req  in  1  one-cycle pulse, line severed
- h_position  out  14  hook x, 1/10 px
- v_position  out  14  hook y, 1/10 px
- cut  out  1  line is severed
- cut_v  out  10  severed-line bottom row, px
- busy  out  1  state != IDLE
- catch_pulse  out  1  one cycle on successful catch
- catch_cnt  out  8  catches so far (only with HOOK_CATCH_CNT_EN)

## Operation
- Reset values: state IDLE, h_position=H_HOME, v_position=V_HOME, cut=0, cut_v=62, busy=0, catch_pulse=0, catch_cnt=0.
- h_position is constant H_HOME.
- States: IDLE, SINK, BOTTOM, REEL, HOOKED, CUT.
- IDLE: btn_cast -> SINK. fish_hit/cut_req/btn_reel ignored.
- SINK: each frame_tick v += SINK_STEP, saturating at V_MAX; when v reaches V_MAX -> BOTTOM. btn_reel -> REEL.
- BOTTOM: v held. btn_reel -> REEL.
- REEL: each frame_tick v -= REEL_STEP, saturating at V_HOME; reaching V_HOME -> IDLE, no catch_pulse.
- HOOKED: entered on fish_hit from SINK, BOTTOM or REEL. Reels automatically: each frame_tick v -= HOOKED_STEP, saturating at V_HOME. Reaching V_HOME -> IDLE with one-cycle catch_pulse. Buttons ignored.
- CUT: entered on cut_req from SINK, BOTTOM, REEL or HOOKED. On entry cut=1 and cut_v=v_position/10 (truncating) at that cycle. Each frame_tick: v += SINK_STEP, saturating at V_MAX; cut_v -= CUT_STEP, saturating at 62. When cut_v reaches 62 (hook position irrelevant) -> IDLE; v reset to V_HOME, cut=0.
- Priority for same-cycle events: cut_req > fish_hit > btn_reel > btn_cast.
- Event pulses and frame_tick in the same cycle: transition taken, position step applied by the new state's rule on the next frame_tick only; the current tick's step is discarded.
- All arithmetic is unsigned 14-bit. Saturation is checked before the write; no wrap-around.

## Timing
- Registered outputs. A transition takes effect on the rising clk edge sampling the pulse. Outputs visible the next cycle.
- Position/cut_v change only on edges where frame_tick=1.
- catch_pulse is asserted the cycle after the edge that loads v=V_HOME in HOOKED; it is high for exactly one cycle.
- Asynchronous rst_n assertion mid-operation forces all reset values immediately. Deassertion is synchronised externally.

## Configuration
- HOOK_CATCH_CNT_EN defined: catch_cnt port and 8-bit counter exist. Counter increments with catch_pulse and saturates at 255.
- Not defined: no catch_cnt port and no counter. All other behaviour is identical.

## Structure
- hook_pkg: state enum, LINE_ROW=62 constant, position width constant 14.
- Sub-module div10: combinational 14-bit / 10 -> 10-bit truncating divider, used for cut_v capture.

## Test plan
- Reset, btn_cast, 272 frame_ticks -> v_position 620->4700 in steps of 15, state BOTTOM, busy=1.
- From BOTTOM, btn_reel, 136 frame_ticks -> v=620, IDLE, catch_pulse never high.
- Cast, 100 ticks (v=2120), fish_hit, 150 ticks -> v=620, single catch_pulse; catch_cnt=1 with the macro.
- Cast, 92 ticks (v=2000), cut_req -> cut=1, cut_v=200. After 69 ticks cut_v=62, IDLE, cut=0, v=620.
- cut_req and fish_hit in the same cycle during SINK -> CUT, no catch. btn_cast in REEL is ignored.
- rst_n low during HOOKED -> all outputs at reset values that same cycle.

Source files
------------

// File: rtl/hook_pkg.sv
// rtl/hook_pkg.sv - shared constants and state type for the hook/line controller
package hook_pkg;

  localparam int POS_W = 14;
  localparam int CUT_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SINK,
    ST_BOTTOM,
    ST_REEL,
    ST_HOOKED,
    ST_CUT
  } state_t;

  localparam logic [POS_W-1:0] H_HOME      = 14'd2790;
  localparam logic [POS_W-1:0] V_HOME      = 14'd620;
  localparam logic [POS_W-1:0] V_MAX       = 14'd4700;
  localparam logic [POS_W-1:0] SINK_STEP   = 14'd15;
  localparam logic [POS_W-1:0] REEL_STEP   = 14'd30;
  localparam logic [POS_W-1:0] HOOKED_STEP = 14'd10;
  localparam logic [CUT_W-1:0] LINE_ROW    = 10'd62;
  localparam logic [CUT_W-1:0] CUT_STEP    = 10'd2;

endpackage

// File: rtl/div10.sv
// rtl/div10.sv - combinational truncating divide-by-ten of a hook position into pixel rows
module div10
  import hook_pkg::*;
(
  input  logic [POS_W-1:0] dividend,
  output logic [CUT_W-1:0] quotient
);

  // Hook positions never exceed V_MAX, so the quotient always fits the row width.
  assign quotient = CUT_W'(dividend / 14'd10);

endmodule

// File: rtl/hook_ctrl.sv
// rtl/hook_ctrl.sv - per-frame hook/line position controller; HOOK_CATCH_CNT_EN adds a catch counter
module hook_ctrl
  import hook_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             btn_cast,
  input  logic             btn_reel,
  input  logic             fish_hit,
  input  logic             cut_req,
  output logic [POS_W-1:0] h_position,
  output logic [POS_W-1:0] v_position,
  output logic             cut,
  output logic [CUT_W-1:0] cut_v,
  output logic             busy,
  output logic             catch_pulse
`ifdef HOOK_CATCH_CNT_EN
  ,
  output logic [7:0]       catch_cnt
`endif
);

  state_t           state_q, state_d;
  logic [POS_W-1:0] v_q, v_d;
  logic [CUT_W-1:0] cut_v_q, cut_v_d;
  logic             catch_q, catch_d;
  logic [CUT_W-1:0] v_row;
  logic [POS_W-1:0] sink_v, reel_v, hooked_v;
  logic [CUT_W-1:0] cut_dec;

  div10 u_div10 (
    .dividend (v_q),
    .quotient (v_row)
  );

  // Saturating steps: the bound is tested before the add/subtract so nothing wraps.
  assign sink_v   = (v_q >= V_MAX - SINK_STEP)    ? V_MAX    : v_q + SINK_STEP;
  assign reel_v   = (v_q <= V_HOME + REEL_STEP)   ? V_HOME   : v_q - REEL_STEP;
  assign hooked_v = (v_q <= V_HOME + HOOKED_STEP) ? V_HOME   : v_q - HOOKED_STEP;
  assign cut_dec  = (cut_v_q <= LINE_ROW + CUT_STEP) ? LINE_ROW : cut_v_q - CUT_STEP;

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cut_v_d = cut_v_q;
    catch_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_cast) state_d = ST_SINK;
      end
      ST_SINK, ST_BOTTOM, ST_REEL: begin
        // Any taken transition swallows a coincident frame step.
        if (cut_req) begin
          state_d = ST_CUT;
          cut_v_d = v_row;
        end else if (fish_hit) begin
          state_d = ST_HOOKED;
        end else if (btn_reel && state_q != ST_REEL) begin
          state_d = ST_REEL;
        end else if (frame_tick) begin
          if (state_q == ST_SINK) begin
            v_d = sink_v;
            if (sink_v == V_MAX) state_d = ST_BOTTOM;
          end else if (state_q == ST_REEL) begin
            v_d = reel_v;
            if (reel_v == V_HOME) state_d = ST_IDLE;
          end
        end
      end
      ST_HOOKED: begin
        if (cut_req) begin
          state_d = ST_CUT;
          cut_v_d = v_row;
        end else if (frame_tick) begin
          v_d = hooked_v;
          if (hooked_v == V_HOME) begin
            state_d = ST_IDLE;
            catch_d = 1'b1;
          end
        end
      end
      ST_CUT: begin
        if (frame_tick) begin
          cut_v_d = cut_dec;
          if (cut_dec == LINE_ROW) begin
            state_d = ST_IDLE;
            v_d     = V_HOME;
          end else begin
            v_d = sink_v;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      v_q     <= V_HOME;
      cut_v_q <= LINE_ROW;
      catch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cut_v_q <= cut_v_d;
      catch_q <= catch_d;
    end
  end

`ifdef HOOK_CATCH_CNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else if (catch_d && cnt_q != 8'hff) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign catch_cnt = cnt_q;
`endif

  assign h_position  = H_HOME;
  assign v_position  = v_q;
  assign cut         = (state_q == ST_CUT);
  assign cut_v       = cut_v_q;
  assign busy        = (state_q != ST_IDLE);
  assign catch_pulse = catch_q;

endmodule

// File: tb/tb_hook_ctrl.sv
// tb/tb_hook_ctrl.sv - self-checking bench for hook_ctrl: vector table, corner sequences, random vs model
module tb_hook_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0, btn_cast = 1'b0, btn_reel = 1'b0, fish_hit = 1'b0, cut_req = 1'b0;
  logic [13:0] h_position, v_position;
  logic        cut, busy, catch_pulse;
  logic [9:0]  cut_v;
`ifdef HOOK_CATCH_CNT_EN
  logic [7:0]  catch_cnt;
`endif

  hook_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .btn_cast    (btn_cast),
    .btn_reel    (btn_reel),
    .fish_hit    (fish_hit),
    .cut_req     (cut_req),
    .h_position  (h_position),
    .v_position  (v_position),
    .cut         (cut),
    .cut_v       (cut_v),
    .busy        (busy),
    .catch_pulse (catch_pulse)
`ifdef HOOK_CATCH_CNT_EN
    ,
    .catch_cnt   (catch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Behavioural reference: mode 0 idle, 1 sink, 2 bottom, 3 reel, 4 hooked, 5 cut
  int m_mode, m_v, m_cutv, m_catch, m_cnt;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction
  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_v = 620; m_cutv = 62; m_catch = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit ft, input bit c, input bit r, input bit h, input bit x);
    m_catch = 0;
    if (m_mode == 0) begin
      if (c) m_mode = 1;
    end else if (m_mode >= 1 && m_mode <= 3) begin
      if (x) begin m_mode = 5; m_cutv = m_v / 10; end
      else if (h) m_mode = 4;
      else if (r && m_mode != 3) m_mode = 3;
      else if (ft && m_mode == 1) begin
        m_v = imin(m_v + 15, 4700);
        if (m_v == 4700) m_mode = 2;
      end else if (ft && m_mode == 3) begin
        m_v = imax(m_v - 30, 620);
        if (m_v == 620) m_mode = 0;
      end
    end else if (m_mode == 4) begin
      if (x) begin m_mode = 5; m_cutv = m_v / 10; end
      else if (ft) begin
        m_v = imax(m_v - 10, 620);
        if (m_v == 620) begin m_mode = 0; m_catch = 1; m_cnt = imin(m_cnt + 1, 255); end
      end
    end else if (ft) begin
      m_cutv = imax(m_cutv - 2, 62);
      if (m_cutv == 62) begin m_mode = 0; m_v = 620; end
      else m_v = imin(m_v + 15, 4700);
    end
  endtask

  task automatic cyc(input bit ft, input bit c, input bit r, input bit h, input bit x);
    frame_tick = ft; btn_cast = c; btn_reel = r; fish_hit = h; cut_req = x;
    model_step(ft, c, r, h, x);
    @(posedge clk);
    #1;
    frame_tick = 1'b0; btn_cast = 1'b0; btn_reel = 1'b0; fish_hit = 1'b0; cut_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit ft, c, r, h, x;
    int v;
    bit busy;
    bit cut;
    int cutv;
    bit catch_p;
  } vec_t;

  vec_t vt[15];
  int catches;

  initial begin
    vt[0]  = '{0,1,0,0,0,  620,1,0,62,0};
    vt[1]  = '{1,0,0,0,0,  635,1,0,62,0};
    vt[2]  = '{1,1,0,0,0,  650,1,0,62,0};
    vt[3]  = '{1,0,1,0,0,  650,1,0,62,0};
    vt[4]  = '{1,0,0,0,0,  620,0,0,62,0};
    vt[5]  = '{1,0,1,0,0,  620,0,0,62,0};
    vt[6]  = '{0,1,0,0,0,  620,1,0,62,0};
    vt[7]  = '{1,0,0,1,1,  620,1,1,62,0};
    vt[8]  = '{1,0,0,0,0,  620,0,0,62,0};
    vt[9]  = '{0,1,0,0,0,  620,1,0,62,0};
    vt[10] = '{1,0,0,0,0,  635,1,0,62,0};
    vt[11] = '{0,0,0,1,0,  635,1,0,62,0};
    vt[12] = '{1,0,1,0,0,  625,1,0,62,0};
    vt[13] = '{1,0,0,0,0,  620,0,0,62,1};
    vt[14] = '{0,0,0,0,0,  620,0,0,62,0};

    do_reset();
    chk("reset_h", h_position, 2790);
    chk("reset_v", v_position, 620);
    chk("reset_cut", cut, 0);
    chk("reset_cutv", cut_v, 62);
    chk("reset_busy", busy, 0);
    chk("reset_catch", catch_pulse, 0);
`ifdef HOOK_CATCH_CNT_EN
    chk("reset_cnt", catch_cnt, 0);
`endif

    for (int i = 0; i < 15; i++) begin
      cyc(vt[i].ft, vt[i].c, vt[i].r, vt[i].h, vt[i].x);
      chk($sformatf("vec%0d_v", i), v_position, vt[i].v);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].busy);
      chk($sformatf("vec%0d_cut", i), cut, vt[i].cut);
      chk($sformatf("vec%0d_cutv", i), cut_v, vt[i].cutv);
      chk($sformatf("vec%0d_catch", i), catch_pulse, vt[i].catch_p);
    end

    // Full cast to the bottom, then an empty reel back
    do_reset();
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 272; i++) begin
      cyc(1, 0, 0, 0, 0);
      chk("sink_v", v_position, 620 + 15 * (i + 1));
    end
    cyc(1, 0, 0, 0, 0);
    chk("bottom_hold_v", v_position, 4700);
    chk("bottom_busy", busy, 1);
    cyc(0, 0, 1, 0, 0);
    catches = 0;
    for (int i = 0; i < 136; i++) begin
      cyc(1, (i == 5), 0, 0, 0);
      catches += catch_pulse;
      chk("reel_v", v_position, 4700 - 30 * (i + 1));
    end
    cyc(0, 0, 0, 0, 0);
    catches += catch_pulse;
    chk("reel_no_catch", catches, 0);
    chk("reel_idle", busy, 0);

    // Hooked fish reeled in
    do_reset();
    cyc(0, 1, 0, 0, 0);
    repeat (100) cyc(1, 0, 0, 0, 0);
    chk("cast100_v", v_position, 2120);
    cyc(0, 0, 0, 1, 0);
    catches = 0;
    for (int i = 0; i < 150; i++) begin
      cyc(1, 0, (i == 3), 0, 0);
      catches += catch_pulse;
    end
    chk("hooked_v", v_position, 620);
    chk("hooked_idle", busy, 0);
    cyc(0, 0, 0, 0, 0);
    catches += catch_pulse;
    chk("hooked_one_catch", catches, 1);
`ifdef HOOK_CATCH_CNT_EN
    chk("catch_cnt", catch_cnt, 1);
`endif

    // Line cut and drift
    do_reset();
    cyc(0, 1, 0, 0, 0);
    repeat (92) cyc(1, 0, 0, 0, 0);
    chk("cast92_v", v_position, 2000);
    cyc(0, 0, 0, 0, 1);
    chk("cut_flag", cut, 1);
    chk("cut_v_entry", cut_v, 200);
    repeat (68) cyc(1, 0, 0, 0, 0);
    chk("cut68_cutv", cut_v, 64);
    chk("cut68_v", v_position, 3020);
    chk("cut68_busy", busy, 1);
    cyc(1, 0, 0, 0, 0);
    chk("cut_end_cutv", cut_v, 62);
    chk("cut_end_cut", cut, 0);
    chk("cut_end_v", v_position, 620);
    chk("cut_end_busy", busy, 0);

    // Asynchronous reset while hooked
    cyc(0, 1, 0, 0, 0);
    repeat (10) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (5) cyc(1, 0, 0, 0, 0);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_v", v_position, 620);
    chk("arst_busy", busy, 0);
    chk("arst_cut", cut, 0);
    chk("arst_cutv", cut_v, 62);
    chk("arst_catch", catch_pulse, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Random pulses against the reference model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 2) == 0, ($urandom % 10) == 0, ($urandom % 25) == 0,
          ($urandom % 40) == 0, ($urandom % 60) == 0);
      chk("rand_state",
          int'({v_position, cut, cut_v, busy, catch_pulse}),
          int'({14'(m_v), (m_mode == 5), 10'(m_cutv), (m_mode != 0), m_catch[0]}));
`ifdef HOOK_CATCH_CNT_EN
      chk("rand_cnt", catch_cnt, m_cnt);
`endif
    end
    chk("rand_h", h_position, 2790);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
